onewire_master_ctl: RTL and testbench

Synthesizable 1-wire bus master that issues reset/presence and single-bit data slots on the open-drain `owr` line. It sits between a simple command/response handshake, driven by a byte-level sequencer or CPU register block, and the physical 1-wire bus. Slave devices attach to that bus and answer presence and read slots. All slot timing is derived from the clock through a compile-time clocks-per-microsecond parameter.

---
 rtl/onewire_pkg.sv | 23 ++
 rtl/onewire_sync.sv | 22 ++
 rtl/onewire_master_ctl.sv | 135 +++++++++++++
 tb/tb_onewire_master_ctl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/onewire_pkg.sv
// Shared 1-wire master definitions: FSM states, standard-speed slot timing in microseconds,
// overdrive divisor and synchronizer depth.
package onewire_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RST  = 2'd1,
      DAT  = 2'd2
   } state_t;

   localparam int T_LOW1_US = 6;
   localparam int T_LOW0_US = 60;
   localparam int T_SMP_US  = 15;
   localparam int T_SLOT_US = 70;
   localparam int T_RSTL_US = 480;
   localparam int T_PDS_US  = 550;
   localparam int T_RSTT_US = 960;

   localparam int OVD_DIV   = 8;
   localparam int OVD_SHIFT = $clog2(OVD_DIV);
   localparam int SYNC_LAT  = 2;

endpackage

// File: rtl/onewire_sync.sv
// Two-flop synchronizer for the raw 1-wire level; latency 2 cycles, no backpressure.
// Resets to 1 so that a released bus is seen during and right after reset.
module onewire_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/onewire_master_ctl.sv
// 1-wire master: one reset/presence or data slot per accepted command, response strobe T_SLOT/T_RSTT after accept;
// cmd_rdy is low for the whole slot. Optional overdrive timing via ONEWIRE_MASTER_OVD_EN.
module onewire_master_ctl
   import onewire_pkg::*;
#(
   parameter int CDR = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic cmd_vld,
   output logic cmd_rdy,
   input  logic cmd_rst,
   input  logic cmd_dat,
`ifdef ONEWIRE_MASTER_OVD_EN
   input  logic cmd_ovd,
`endif
   output logic rsp_vld,
   output logic rsp_dat,
   output logic owr_oe,
   input  logic owr_i
);

   localparam int CW = $clog2(T_RSTT_US * CDR);
   typedef logic [CW-1:0] cnt_t;

   if (CDR < 1) begin : g_cdr_min
      $error("onewire_master_ctl: CDR must be at least 1");
   end

   state_t state;
   cnt_t   cnt;
   cnt_t   cnt_nxt;
   cnt_t   t_low;
   cnt_t   t_smp;
   cnt_t   t_end;
   cnt_t   smp_pt;
   logic   lat_rst;
   logic   lat_dat;
   logic   smp;
   logic   bus;

`ifdef ONEWIRE_MASTER_OVD_EN
   logic lat_ovd;

   if (CDR % OVD_DIV != 0) begin : g_cdr_ovd
      $error("onewire_master_ctl: CDR must be a multiple of 8 with overdrive enabled");
   end
`endif

   onewire_sync u_sync (
      .clk (clk),
      .rst (rst),
      .d   (owr_i),
      .q   (bus)
   );

   // Thresholds follow the latched command; overdrive is an exact shift since CDR is a multiple of 8.
   always_comb begin
      t_low = cnt_t'(T_LOW0_US * CDR);
      t_smp = cnt_t'(T_SMP_US * CDR);
      t_end = cnt_t'(T_SLOT_US * CDR);
      if (lat_rst) begin
         t_low = cnt_t'(T_RSTL_US * CDR);
         t_smp = cnt_t'(T_PDS_US * CDR);
         t_end = cnt_t'(T_RSTT_US * CDR);
      end else if (lat_dat) begin
         t_low = cnt_t'(T_LOW1_US * CDR);
      end
`ifdef ONEWIRE_MASTER_OVD_EN
      if (lat_ovd) begin
         t_low = t_low >> OVD_SHIFT;
         t_smp = t_smp >> OVD_SHIFT;
         t_end = t_end >> OVD_SHIFT;
      end
`endif
   end

   assign smp_pt  = t_smp + cnt_t'(SYNC_LAT);
   assign cnt_nxt = cnt + cnt_t'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         lat_rst <= 1'b0;
         lat_dat <= 1'b0;
`ifdef ONEWIRE_MASTER_OVD_EN
         lat_ovd <= 1'b0;
`endif
         smp     <= 1'b0;
         cmd_rdy <= 1'b1;
         rsp_vld <= 1'b0;
         rsp_dat <= 1'b0;
         owr_oe  <= 1'b0;
      end else begin
         rsp_vld <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_vld) begin
                  state   <= cmd_rst ? RST : DAT;
                  cnt     <= '0;
                  lat_rst <= cmd_rst;
                  lat_dat <= cmd_dat;
`ifdef ONEWIRE_MASTER_OVD_EN
                  lat_ovd <= cmd_ovd;
`endif
                  cmd_rdy <= 1'b0;
                  owr_oe  <= 1'b1;
               end
            end
            RST, DAT: begin
               cnt    <= cnt_nxt;
               owr_oe <= (cnt_nxt < t_low);
               // Presence is a slave pulling low, so the reset slot inverts the sampled level.
               if (cnt == smp_pt) begin
                  smp <= lat_rst ? ~bus : bus;
               end
               if (cnt_nxt == t_end) begin
                  state   <= IDLE;
                  cmd_rdy <= 1'b1;
                  rsp_vld <= 1'b1;
                  rsp_dat <= smp;
                  owr_oe  <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               cmd_rdy <= 1'b1;
               owr_oe  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_onewire_master_ctl.sv
// Bench for onewire_master_ctl: directed slots plus randomized slots against a bus-level timing model.
module tb_onewire_master_ctl;

   localparam int CDR = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic cmd_vld = 1'b0;
   logic cmd_rst = 1'b0;
   logic cmd_dat = 1'b0;
`ifdef ONEWIRE_MASTER_OVD_EN
   logic cmd_ovd = 1'b0;
`endif
   logic cmd_rdy;
   logic rsp_vld;
   logic rsp_dat;
   logic owr_oe;
   logic owr_i;
   logic slave_pull = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;
   int last_exp = 0;

   // Open-drain bus with pull-up: low if master or slave pulls.
   assign owr_i = ~(owr_oe | slave_pull);

   always #5 clk = ~clk;

   onewire_master_ctl #(.CDR(CDR)) dut (
      .clk     (clk),
      .rst     (rst),
      .cmd_vld (cmd_vld),
      .cmd_rdy (cmd_rdy),
      .cmd_rst (cmd_rst),
      .cmd_dat (cmd_dat),
`ifdef ONEWIRE_MASTER_OVD_EN
      .cmd_ovd (cmd_ovd),
`endif
      .rsp_vld (rsp_vld),
      .rsp_dat (rsp_dat),
      .owr_oe  (owr_oe),
      .owr_i   (owr_i)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int cyc(input int us, input bit o);
      return o ? (us * CDR) / 8 : us * CDR;
   endfunction

   // Issue one command (accept on the next edge) and follow the slot until the response.
   task automatic do_cmd(input string tag, input bit r, input bit d, input bit o,
                         input int ps, input int pe, input bit noise);
      int e_low, e_end, e_smp, e_dat, n_low, j_rsp;
      bit lvl;
      e_low = r ? cyc(480, o) : cyc(d ? 6 : 60, o);
      e_end = cyc(r ? 960 : 70, o);
      e_smp = cyc(r ? 550 : 15, o);
      lvl   = !((e_smp < e_low) || (e_smp >= ps && e_smp < pe));
      e_dat = r ? int'(!lvl) : int'(lvl);

      chk({tag, ".cmd_rdy"}, cmd_rdy, 1);
      cmd_vld = 1'b1;
      cmd_rst = r;
      cmd_dat = d;
`ifdef ONEWIRE_MASTER_OVD_EN
      cmd_ovd = o;
`endif
      @(posedge clk);
      #1;
      cmd_vld = 1'b0;
      n_low = 0;
      j_rsp = -1;
      for (int j = 0; j <= e_end + 16; j++) begin
         if (j > 0) begin
            @(posedge clk);
            #1;
         end
         slave_pull = (j >= ps && j < pe);
         if (owr_oe === 1'b1) n_low++;
         if (rsp_vld === 1'b1) begin
            j_rsp = j;
            break;
         end
         if (noise && j < e_end - 2) begin
            cmd_vld = 1'($urandom_range(0, 1));
            cmd_rst = 1'($urandom_range(0, 1));
            cmd_dat = 1'($urandom_range(0, 1));
`ifdef ONEWIRE_MASTER_OVD_EN
            cmd_ovd = 1'($urandom_range(0, 1));
`endif
         end else begin
            cmd_vld = 1'b0;
         end
      end
      slave_pull = 1'b0;
      cmd_vld = 1'b0;
      chk({tag, ".low_cycles"}, n_low, e_low);
      chk({tag, ".rsp_cycle"}, j_rsp, e_end);
      chk({tag, ".rsp_dat"}, rsp_dat, e_dat);
      last_exp = e_dat;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
      chk("idle.rsp_vld", rsp_vld, 0);
      chk("idle.rsp_dat_hold", rsp_dat, last_exp);
      chk("idle.owr_oe", owr_oe, 0);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: observed no end of test, required end within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int saw_rsp;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset.cmd_rdy", cmd_rdy, 1);
      chk("reset.rsp_vld", rsp_vld, 0);
      chk("reset.rsp_dat", rsp_dat, 0);
      chk("reset.owr_oe", owr_oe, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Reset/presence with a slave answering, then with an empty bus.
      do_cmd("rst_pres", 1'b1, 1'b0, 1'b0, 4000, 5600, 1'b0);
      idle(4);
      do_cmd("rst_none", 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
      idle(2);

      // Write 0 then write 1 back to back, accept in the response cycle.
      do_cmd("wr0", 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
      do_cmd("wr1", 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
      idle(3);

      // Read slots: slave holds low until 30 us, then a silent slave.
      do_cmd("rd_pull", 1'b0, 1'b1, 1'b0, 8, 240, 1'b1);
      do_cmd("rd_idle", 1'b0, 1'b1, 1'b0, 0, 0, 1'b1);
      idle(3);

      // Asynchronous reset in the middle of a write-0 slot.
      cmd_vld = 1'b1;
      cmd_rst = 1'b0;
      cmd_dat = 1'b0;
      @(posedge clk);
      #1;
      cmd_vld = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      chk("abort.oe_before", owr_oe, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("abort.oe_released", owr_oe, 0);
      chk("abort.cmd_rdy_in_rst", cmd_rdy, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      last_exp = 0;
      saw_rsp = 0;
      for (int k = 0; k < 700; k++) begin
         @(posedge clk);
         #1;
         if (rsp_vld !== 1'b0 || owr_oe !== 1'b0) saw_rsp++;
      end
      chk("abort.no_rsp_no_drive", saw_rsp, 0);
      chk("abort.cmd_rdy", cmd_rdy, 1);
      chk("abort.rsp_dat", rsp_dat, 0);

`ifdef ONEWIRE_MASTER_OVD_EN
      do_cmd("ovd_rst", 1'b1, 1'b0, 1'b1, 500, 700, 1'b0);
      do_cmd("ovd_wr0", 1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
      idle(3);
`endif

      // Randomized slots with random slave windows and command noise during the slot.
      for (int i = 0; i < 20; i++) begin
         bit r, d, o;
         int es, ps, pe;
         r = (i % 8 == 7);
         d = 1'($urandom_range(0, 1));
         o = 1'b0;
`ifdef ONEWIRE_MASTER_OVD_EN
         o = 1'($urandom_range(0, 1));
`endif
         es = cyc(r ? 550 : 15, o);
         ps = int'($urandom_range(0, cyc(r ? 960 : 70, o) - 1));
         pe = ps + int'($urandom_range(1, cyc(r ? 300 : 40, o)));
         if (ps > es - 3 && ps < es + 3) ps = es + 3;
         if (pe > es - 3 && pe < es + 3) pe = es + 3;
         do_cmd($sformatf("rnd%0d", i), r, d, o, ps, pe, 1'b1);
         if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 5)));
      end
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
